muldiv_sequencer: RTL and testbench

- Multi-cycle controller and iterative datapath for RV32M instructions issued from the EX stage.
- Accepts a level-held START with funct3 and operands, then sequences a registered multiplier or a 32-step restoring divider.
- Returns a held result with a READY flag that the EX stage uses as its stall release.
- Caches the last completed division so that a DIV/REM pair on identical operands finishes in one cycle.

---
 rtl/muldiv_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle sequencer and datapath for RV32M operations issued from EX.
//   Multiplies use a registered product held for MUL_LAT cycles. Divides use
//   a 32-step restoring divider followed by a sign-fix cycle. The last
//   completed division is kept in a reuse tag, so a DIV/REM pair on the same
//   operands finishes the second operation in one cycle.
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   START        level request, held by EX while it is stalled
//   KILL         pipeline flush, aborts any operation
//   CACHE_READY  pipeline advance; the result is consumed on READY & CACHE_READY
//   M_CNT[2:0]   funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   RS1, RS2     operands
//   OUT          registered result, held until the next result is written
//   READY        result valid (DONE state)
//   BUSY         operation in flight (MUL, DIV, FIX)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for START; operands latched on accept
// MUL   | product settling, MUL_LAT cycles
// DIV   | one restoring shift-subtract step per cycle, 32 cycles
// FIX   | apply quotient/remainder signs, update reuse tag
// DONE  | OUT valid, READY high until CACHE_READY consumes it

module muldiv_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            KILL,
    input  logic            CACHE_READY,
    input  logic [2:0]      M_CNT,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic [XLEN-1:0] OUT,
    output logic            READY,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] rs1_q, rs2_q;
    logic [31:0] rem_q, quo_q, dvs_q;

    logic        tag_vld_q;
    logic [31:0] tag_rs1_q, tag_rs2_q;
    logic        tag_sgn_q;
    logic [31:0] tag_quo_q, tag_rem_q;

    // ---------------------------------------------------------------
    // Accept-time decode on the live request
    // ---------------------------------------------------------------
    logic        in_div, in_sgn, in_rem;
    logic        div_zero, div_ovf, tag_hit;
    logic [31:0] fast_quo, fast_rem, fast_out;
    logic [31:0] abs_rs1, abs_rs2;

    assign in_div   = M_CNT[2];
    assign in_sgn   = ~M_CNT[0];
    assign in_rem   = M_CNT[1];
    assign div_zero = (RS2 == 32'd0);
    assign div_ovf  = in_sgn && (RS1 == 32'h8000_0000) && (RS2 == 32'hFFFF_FFFF);
    assign tag_hit  = tag_vld_q && (RS1 == tag_rs1_q) && (RS2 == tag_rs2_q)
                      && (in_sgn == tag_sgn_q);

    always_comb begin
        fast_quo = 32'h8000_0000;
        fast_rem = 32'd0;
        if (tag_hit) begin
            fast_quo = tag_quo_q;
            fast_rem = tag_rem_q;
        end else if (div_zero) begin
            fast_quo = 32'hFFFF_FFFF;
            fast_rem = RS1;
        end
    end

    assign fast_out = in_rem ? fast_rem : fast_quo;
    assign abs_rs1  = (in_sgn && RS1[31]) ? -RS1 : RS1;
    assign abs_rs2  = (in_sgn && RS2[31]) ? -RS2 : RS2;

    // ---------------------------------------------------------------
    // Multiply: 33x33 signed product, only the low 64 bits matter
    // ---------------------------------------------------------------
    logic        mul_sa, mul_sb;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [31:0] mul_out;

    assign mul_sa   = (op_q != 2'b11);
    assign mul_sb   = (op_q == 2'b01);
    assign mul_a    = {{32{mul_sa & rs1_q[31]}}, rs1_q};
    assign mul_b    = {{32{mul_sb & rs2_q[31]}}, rs2_q};
    assign mul_prod = mul_a * mul_b;
    assign mul_out  = (op_q == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

    // ---------------------------------------------------------------
    // Restoring divide step; quo_q doubles as the dividend shift register
    // ---------------------------------------------------------------
    logic [32:0] rem_sh, rem_sub;
    logic        step_ok;

    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign step_ok = ~rem_sub[32];

    logic        fix_sgn, neg_quo, neg_rem;
    logic [31:0] fix_quo, fix_rem, fix_out;

    assign fix_sgn = ~op_q[0];
    assign neg_quo = fix_sgn & (rs1_q[31] ^ rs2_q[31]);
    assign neg_rem = fix_sgn & rs1_q[31];
    assign fix_quo = neg_quo ? -quo_q : quo_q;
    assign fix_rem = neg_rem ? -rem_q : rem_q;
    assign fix_out = op_q[1] ? fix_rem : fix_quo;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    logic accept, take_fast, mul_done, fix_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        take_fast = 1'b0;
        mul_done  = 1'b0;
        fix_done  = 1'b0;
        if (KILL) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        accept = 1'b1;
                        if (!in_div) begin
                            state_d = S_MUL;
                        end else if (tag_hit || div_zero || div_ovf) begin
                            take_fast = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        mul_done = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    if (cnt_q == 5'd0) state_d = S_FIX;
                end
                S_FIX: begin
                    fix_done = 1'b1;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (CACHE_READY) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign READY = (state_q == S_DONE);
    assign BUSY  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

    // ---------------------------------------------------------------
    // Operand latch, counter and divider datapath
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= 5'd0;
            op_q  <= 2'b00;
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
        end else if (accept) begin
            op_q  <= M_CNT[1:0];
            rs1_q <= RS1;
            rs2_q <= RS2;
            rem_q <= 32'd0;
            quo_q <= abs_rs1;
            dvs_q <= abs_rs2;
            cnt_q <= in_div ? 5'd31 : 5'(MUL_LAT - 1);
        end else if (state_q == S_DIV) begin
            rem_q <= step_ok ? rem_sub[31:0] : rem_sh[31:0];
            quo_q <= {quo_q[30:0], step_ok};
            cnt_q <= cnt_q - 5'd1;
        end else if (state_q == S_MUL && cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
        end
    end

    // ---------------------------------------------------------------
    // Result register and reuse tag
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT <= '0;
        end else if (take_fast) begin
            OUT <= fast_out;
        end else if (mul_done) begin
            OUT <= mul_out;
        end else if (fix_done) begin
            OUT <= fix_out;
        end
    end

    // A hit rewrites the tag with its own contents, which keeps the write
    // enable simple.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_vld_q <= 1'b0;
            tag_rs1_q <= 32'd0;
            tag_rs2_q <= 32'd0;
            tag_sgn_q <= 1'b0;
            tag_quo_q <= 32'd0;
            tag_rem_q <= 32'd0;
        end else if (take_fast) begin
            tag_vld_q <= 1'b1;
            tag_rs1_q <= RS1;
            tag_rs2_q <= RS2;
            tag_sgn_q <= in_sgn;
            tag_quo_q <= fast_quo;
            tag_rem_q <= fast_rem;
        end else if (fix_done) begin
            tag_vld_q <= 1'b1;
            tag_rs1_q <= rs1_q;
            tag_rs2_q <= rs2_q;
            tag_sgn_q <= fix_sgn;
            tag_quo_q <= fix_quo;
            tag_rem_q <= fix_rem;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int MUL_LAT = 2;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        KILL;
    logic        CACHE_READY;
    logic [2:0]  M_CNT;
    logic [31:0] RS1, RS2;
    logic [31:0] OUT;
    logic        READY, BUSY;

    muldiv_sequencer #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .START       (START),
        .KILL        (KILL),
        .CACHE_READY (CACHE_READY),
        .M_CNT       (M_CNT),
        .RS1         (RS1),
        .RS2         (RS2),
        .OUT         (OUT),
        .READY       (READY),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    typedef struct {
        logic [31:0] val;
        int          lat;
        int          t;
    } exp_t;

    exp_t sb_q[$];

    logic        m_tag_vld = 1'b0;
    logic [31:0] m_tag_a, m_tag_b;
    logic        m_tag_s;
    logic [31:0] last_out = 32'd0;

    function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = longint'(64'(ua * ub) >> 32);
            3'd4: p = (b == 0) ? -1 : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? sa : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        if (!op[2]) return MUL_LAT + 1;
        sgn = ~op[0];
        if (m_tag_vld && a == m_tag_a && b == m_tag_b && sgn == m_tag_s) return 1;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // ---------------------------------------------------------------
    // Monitor: pops on every READY rise and checks hold while stalled
    // ---------------------------------------------------------------
    logic        ready_d = 1'b0;
    logic [31:0] held_out = 32'd0;

    always begin
        @(posedge CLK);
        #1;
        if (READY && !ready_d) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {31'd0, READY}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", OUT, e.val);
                check("latency", 32'(cyc - e.t), 32'(e.lat));
            end
            held_out = OUT;
        end else if (READY && ready_d) begin
            check("out_hold", OUT, held_out);
        end
        ready_d = READY;
    end

    // ---------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        logic got;
        e.val = ref_calc(op, a, b);
        e.lat = ref_lat(op, a, b);
        if (op[2]) begin
            m_tag_vld = 1'b1;
            m_tag_a   = a;
            m_tag_b   = b;
            m_tag_s   = ~op[0];
        end
        last_out = e.val;
        @(negedge CLK);
        START       = 1'b1;
        M_CNT       = op;
        RS1         = a;
        RS2         = b;
        CACHE_READY = 1'b0;
        e.t = cyc;
        sb_q.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (READY) begin
                got = 1'b1;
                break;
            end
            check("busy_in_flight", {31'd0, BUSY}, 32'd1);
        end
        if (!got) begin
            check("ready_timeout", {31'd0, READY}, 32'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
            START = 1'b0;
            return;
        end
        check("busy_at_done", {31'd0, BUSY}, 32'd0);
        repeat (stall) @(negedge CLK);
        CACHE_READY = 1'b1;
        @(negedge CLK);
        START       = 1'b0;
        CACHE_READY = 1'b0;
        check("ready_after_consume", {31'd0, READY}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa, pb, a, b;
        logic [2:0]  op;
        int          t0;

        RST_N = 1'b0; START = 1'b0; KILL = 1'b0; CACHE_READY = 1'b0;
        M_CNT = 3'd0; RS1 = 32'd0; RS2 = 32'd0;
        #2;
        check("reset_out",   OUT, 32'd0);
        check("reset_ready", {31'd0, READY}, 32'd0);
        check("reset_busy",  {31'd0, BUSY}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // multiplies
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);

        // full divide then reuse hit
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);

        // special cases
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // KILL in the accept cycle wins over START
        @(negedge CLK);
        START = 1'b1; KILL = 1'b1; M_CNT = 3'd5; RS1 = 32'd100; RS2 = 32'd7;
        @(posedge CLK);
        #1;
        check("kill_at_accept_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        START = 1'b0; KILL = 1'b0;

        // KILL mid-divide
        @(negedge CLK);
        START = 1'b1; M_CNT = 3'd5; RS1 = 32'd100; RS2 = 32'd7;
        t0 = cyc;
        repeat (5) @(negedge CLK);
        check("kill_busy_mid", {31'd0, BUSY}, 32'd1);
        repeat (5) @(negedge CLK);
        check("kill_cycle_t10", 32'(cyc - t0), 32'd10);
        KILL = 1'b1; START = 1'b0;
        @(posedge CLK);
        #1;
        check("kill_ready", {31'd0, READY}, 32'd0);
        check("kill_busy",  {31'd0, BUSY}, 32'd0);
        check("kill_out",   OUT, last_out);
        @(negedge CLK);
        KILL = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);

        // long CACHE_READY stall
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3);

        // reset mid-divide
        @(negedge CLK);
        START = 1'b1; M_CNT = 3'd4; RS1 = 32'h1234_5678; RS2 = 32'h0000_0123;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0; START = 1'b0;
        #1;
        check("rst_mid_out",   OUT, 32'd0);
        check("rst_mid_ready", {31'd0, READY}, 32'd0);
        check("rst_mid_busy",  {31'd0, BUSY}, 32'd0);
        m_tag_vld = 1'b0;
        last_out  = 32'd0;
        @(negedge CLK);
        RST_N = 1'b1;
        run_op(3'd6, 32'h1234_5678, 32'h0000_0123, 0);

        // randomized traffic
        pa = 32'd1; pb = 32'd1;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    begin a = pa; b = pb; end
                4:       begin a = $urandom; b = 32'($urandom_range(1, 15)); end
                5:       begin a = $urandom; b = -32'($urandom_range(1, 15)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(op, a, b, $urandom_range(0, 2));
            pa = a; pb = b;
        end

        repeat (3) @(negedge CLK);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
